// File: rtl/core_pkg.sv
// Shared types and constants for the core trap sequencer.
// Optional build macro used by core_trap_ctrl: CORE_TRAP_TVAL_EN (adds xTVAL update).
package core_pkg;

    typedef enum logic [1:0] {
        PRV_U = 2'b00,
        PRV_S = 2'b01,
        PRV_M = 2'b11
    } prv_mode_t;

    typedef enum logic [1:0] {
        TRAP_IDLE     = 2'd0,
        TRAP_FLUSH    = 2'd1,
        TRAP_COMMIT   = 2'd2,
        TRAP_REDIRECT = 2'd3
    } trap_state_t;

    // mstatus bit positions
    localparam int MSTATUS_SIE    = 1;
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_SPIE   = 5;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_SPP    = 8;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // standard interrupt cause codes
    localparam int IRQ_SSI = 1;
    localparam int IRQ_MSI = 3;
    localparam int IRQ_STI = 5;
    localparam int IRQ_MTI = 7;
    localparam int IRQ_SEI = 9;
    localparam int IRQ_MEI = 11;

    // standard causes, highest priority first; all other lines follow by descending index
    localparam int IRQ_STD_CNT = 6;
    localparam int IRQ_STD_PRIO [IRQ_STD_CNT] = '{IRQ_MEI, IRQ_MSI, IRQ_MTI, IRQ_SEI, IRQ_SSI, IRQ_STI};

    function automatic logic irq_is_std(input int idx);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < IRQ_STD_CNT; k++) begin
            if (IRQ_STD_PRIO[k] == idx) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/core_trap_irq_sel.sv
// Interrupt eligibility (delegation + global enables) and fixed-priority winner select.
module core_trap_irq_sel
    import core_pkg::*;
#(
    parameter int NUM_IRQ = 16
) (
    input  logic [NUM_IRQ-1:0] irq_pending,
    input  logic [31:0]        mideleg,
    input  logic [1:0]         prv_mode,
    input  logic               mstatus_mie,
    input  logic               mstatus_sie,
    output logic               irq_valid,
    output logic [4:0]         irq_code,
    output logic               irq_to_m
);

    logic               m_en;
    logic               s_en;
    logic [NUM_IRQ-1:0] to_m;
    logic [NUM_IRQ-1:0] eligible;
    logic               unused_deleg;

    // lines above NUM_IRQ have no delegation meaning here
    assign unused_deleg = ^mideleg;

    // per-line target privilege and whether that target currently accepts interrupts
    always_comb begin
        m_en = (prv_mode < PRV_M) || mstatus_mie;
        s_en = (prv_mode < PRV_S) || ((prv_mode == PRV_S) && mstatus_sie);
        for (int i = 0; i < NUM_IRQ; i++) begin
            to_m[i]     = !mideleg[i] || (prv_mode == PRV_M);
            eligible[i] = irq_pending[i] && (to_m[i] ? m_en : s_en);
        end
        irq_valid = |eligible;
    end

    // later writes win: non-standard lines ascending, then standard lines lowest priority first
    always_comb begin
        irq_code = '0;
        irq_to_m = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (eligible[i] && !irq_is_std(i)) begin
                irq_code = 5'(i);
                irq_to_m = to_m[i];
            end
        end
        for (int k = IRQ_STD_CNT - 1; k >= 0; k--) begin
            if (eligible[IRQ_STD_PRIO[k]]) begin
                irq_code = 5'(IRQ_STD_PRIO[k]);
                irq_to_m = to_m[IRQ_STD_PRIO[k]];
            end
        end
    end

endmodule

// File: rtl/core_trap_ctrl.sv
// Trap / xRET sequencer: accepts an exception, interrupt or MRET/SRET, drains the
// pipeline, commits the implicit CSR and privilege updates, then redirects fetch.
// Build option: define CORE_TRAP_TVAL_EN to add exc_tval and the xTVAL write port.
//
// state         | meaning
// TRAP_IDLE     | waiting for an event; event data latched on acceptance
// TRAP_FLUSH    | flush_req high until flush_ack is seen
// TRAP_COMMIT   | one cycle of CSR / privilege write strobes
// TRAP_REDIRECT | one-cycle fetch redirect, then back to idle
module core_trap_ctrl
    import core_pkg::*;
#(
    parameter int NUM_IRQ      = 16,   // 12..32
    parameter int VECTORED_IRQ = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               exc_valid,
    input  logic [4:0]         exc_cause,
    input  logic [31:0]        trap_pc,
    input  logic [NUM_IRQ-1:0] irq_pending,
    input  logic [1:0]         xret_req,
    input  logic [1:0]         prv_mode,
    input  logic [31:0]        csr_mstatus,
    input  logic [31:0]        csr_medeleg,
    input  logic [31:0]        csr_mideleg,
    input  logic [31:0]        csr_mtvec,
    input  logic [31:0]        csr_stvec,
    input  logic [31:0]        csr_mepc,
    input  logic [31:0]        csr_sepc,
    output logic               flush_req,
    input  logic               flush_ack,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    output logic [1:0]         prv_mode_in,
    output logic               prv_mode_we,
    output logic [31:0]        csr_mstatus_in,
    output logic               csr_mstatus_we,
    output logic [31:0]        csr_epc_in,
    output logic [1:0]         csr_epc_we,
    output logic [31:0]        csr_cause_in,
    output logic [1:0]         csr_cause_we
`ifdef CORE_TRAP_TVAL_EN
    ,
    input  logic [31:0]        exc_tval,
    output logic [31:0]        csr_tval_in,
    output logic [1:0]         csr_tval_we
`endif
);

    trap_state_t state_q, state_d;

    logic        irq_valid;
    logic [4:0]  irq_code;
    logic        irq_to_m;

    logic        ev_valid, is_irq, is_mret, is_sret, to_m_d;
    logic [4:0]  code_d;
    logic [31:0] tvec, mstatus_d, pc_d;
    logic [1:0]  prv_d;

    logic        ev_int_q, ev_ret_q, to_m_q;
    logic [4:0]  code_q;
    logic [31:0] epc_q, mstatus_q, pc_q;
    logic [1:0]  prv_q;
`ifdef CORE_TRAP_TVAL_EN
    logic [31:0] tval_q;
`endif

    core_trap_irq_sel #(
        .NUM_IRQ(NUM_IRQ)
    ) u_irq_sel (
        .irq_pending(irq_pending),
        .mideleg    (csr_mideleg),
        .prv_mode   (prv_mode),
        .mstatus_mie(csr_mstatus[MSTATUS_MIE]),
        .mstatus_sie(csr_mstatus[MSTATUS_SIE]),
        .irq_valid  (irq_valid),
        .irq_code   (irq_code),
        .irq_to_m   (irq_to_m)
    );

    // classify the candidate event and precompute its mstatus, privilege and target PC
    always_comb begin
        ev_valid  = exc_valid || irq_valid || (xret_req != 2'b00);
        is_irq    = !exc_valid && irq_valid;
        is_mret   = !exc_valid && !irq_valid && xret_req[1];
        is_sret   = !exc_valid && !irq_valid && !xret_req[1] && xret_req[0];
        code_d    = exc_valid ? exc_cause : irq_code;
        to_m_d    = exc_valid ? (!csr_medeleg[exc_cause] || (prv_mode == PRV_M)) : irq_to_m;
        tvec      = to_m_d ? csr_mtvec : csr_stvec;
        mstatus_d = csr_mstatus;
        prv_d     = PRV_M;
        pc_d      = {tvec[31:2], 2'b00};
        if (is_mret) begin
            mstatus_d[MSTATUS_MIE]                   = csr_mstatus[MSTATUS_MPIE];
            mstatus_d[MSTATUS_MPIE]                  = 1'b1;
            mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRV_U;
            prv_d = csr_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
            pc_d  = {csr_mepc[31:2], 2'b00};
        end else if (is_sret) begin
            mstatus_d[MSTATUS_SIE]  = csr_mstatus[MSTATUS_SPIE];
            mstatus_d[MSTATUS_SPIE] = 1'b1;
            mstatus_d[MSTATUS_SPP]  = 1'b0;
            prv_d = {1'b0, csr_mstatus[MSTATUS_SPP]};
            pc_d  = {csr_sepc[31:2], 2'b00};
        end else if (to_m_d) begin
            mstatus_d[MSTATUS_MPIE]                  = csr_mstatus[MSTATUS_MIE];
            mstatus_d[MSTATUS_MIE]                   = 1'b0;
            mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = prv_mode;
            prv_d = PRV_M;
        end else begin
            mstatus_d[MSTATUS_SPIE] = csr_mstatus[MSTATUS_SIE];
            mstatus_d[MSTATUS_SIE]  = 1'b0;
            mstatus_d[MSTATUS_SPP]  = prv_mode[0];
            prv_d = PRV_S;
        end
        if (is_irq && (VECTORED_IRQ != 0) && (tvec[1:0] == 2'b01)) begin
            pc_d = pc_d + {25'b0, code_d, 2'b00};
        end
    end

    // capture the event on acceptance; later input changes are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_int_q  <= 1'b0;
            ev_ret_q  <= 1'b0;
            to_m_q    <= 1'b0;
            code_q    <= '0;
            epc_q     <= '0;
            mstatus_q <= '0;
            prv_q     <= '0;
            pc_q      <= '0;
`ifdef CORE_TRAP_TVAL_EN
            tval_q    <= '0;
`endif
        end else if ((state_q == TRAP_IDLE) && ev_valid) begin
            ev_int_q  <= is_irq;
            ev_ret_q  <= is_mret || is_sret;
            to_m_q    <= to_m_d;
            code_q    <= code_d;
            epc_q     <= trap_pc;
            mstatus_q <= mstatus_d;
            prv_q     <= prv_d;
            pc_q      <= pc_d;
`ifdef CORE_TRAP_TVAL_EN
            tval_q    <= is_irq ? 32'h0 : exc_tval;
`endif
        end
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= TRAP_IDLE;
        else     state_q <= state_d;
    end

    // flush request comes straight from a flop so the pipeline sees a clean level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) flush_req <= 1'b0;
        else     flush_req <= (state_d == TRAP_FLUSH);
    end

    // next state and strobe/data outputs; data is zero outside its strobe cycle
    always_comb begin
        state_d        = state_q;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        prv_mode_in    = '0;
        prv_mode_we    = 1'b0;
        csr_mstatus_in = '0;
        csr_mstatus_we = 1'b0;
        csr_epc_in     = '0;
        csr_epc_we     = '0;
        csr_cause_in   = '0;
        csr_cause_we   = '0;
`ifdef CORE_TRAP_TVAL_EN
        csr_tval_in    = '0;
        csr_tval_we    = '0;
`endif
        case (state_q)
            TRAP_IDLE: begin
                if (ev_valid) state_d = TRAP_FLUSH;
            end
            TRAP_FLUSH: begin
                if (flush_ack) state_d = TRAP_COMMIT;
            end
            TRAP_COMMIT: begin
                prv_mode_in    = prv_q;
                prv_mode_we    = 1'b1;
                csr_mstatus_in = mstatus_q;
                csr_mstatus_we = 1'b1;
                if (!ev_ret_q) begin
                    csr_epc_in   = epc_q;
                    csr_epc_we   = to_m_q ? 2'b10 : 2'b01;
                    csr_cause_in = {ev_int_q, 26'b0, code_q};
                    csr_cause_we = to_m_q ? 2'b10 : 2'b01;
`ifdef CORE_TRAP_TVAL_EN
                    csr_tval_in  = tval_q;
                    csr_tval_we  = to_m_q ? 2'b10 : 2'b01;
`endif
                end
                state_d = TRAP_REDIRECT;
            end
            TRAP_REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = pc_q;
                state_d        = TRAP_IDLE;
            end
            default: state_d = TRAP_IDLE;
        endcase
    end

endmodule

// File: tb/tb_core_trap_ctrl.sv
// Self-checking bench for core_trap_ctrl: directed scenarios plus randomized events
// checked against a behavioural model of the trap rules.
module tb_core_trap_ctrl;

    localparam int NUM_IRQ = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               exc_valid;
    logic [4:0]         exc_cause;
    logic [31:0]        trap_pc;
    logic [NUM_IRQ-1:0] irq_pending;
    logic [1:0]         xret_req;
    logic [1:0]         prv_mode;
    logic [31:0]        csr_mstatus, csr_medeleg, csr_mideleg, csr_mtvec, csr_stvec, csr_mepc, csr_sepc;
    logic               flush_req, flush_ack, redirect_valid;
    logic [31:0]        redirect_pc;
    logic [1:0]         prv_mode_in;
    logic               prv_mode_we;
    logic [31:0]        csr_mstatus_in;
    logic               csr_mstatus_we;
    logic [31:0]        csr_epc_in;
    logic [1:0]         csr_epc_we;
    logic [31:0]        csr_cause_in;
    logic [1:0]         csr_cause_we;
`ifdef CORE_TRAP_TVAL_EN
    logic [31:0]        exc_tval = 32'h0;
    logic [31:0]        csr_tval_in;
    logic [1:0]         csr_tval_we;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    core_trap_ctrl #(.NUM_IRQ(NUM_IRQ), .VECTORED_IRQ(1)) dut (
        .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_cause(exc_cause), .trap_pc(trap_pc),
        .irq_pending(irq_pending), .xret_req(xret_req), .prv_mode(prv_mode),
        .csr_mstatus(csr_mstatus), .csr_medeleg(csr_medeleg), .csr_mideleg(csr_mideleg),
        .csr_mtvec(csr_mtvec), .csr_stvec(csr_stvec), .csr_mepc(csr_mepc), .csr_sepc(csr_sepc),
        .flush_req(flush_req), .flush_ack(flush_ack), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .prv_mode_in(prv_mode_in), .prv_mode_we(prv_mode_we),
        .csr_mstatus_in(csr_mstatus_in), .csr_mstatus_we(csr_mstatus_we),
        .csr_epc_in(csr_epc_in), .csr_epc_we(csr_epc_we),
        .csr_cause_in(csr_cause_in), .csr_cause_we(csr_cause_we)
`ifdef CORE_TRAP_TVAL_EN
        , .exc_tval(exc_tval), .csr_tval_in(csr_tval_in), .csr_tval_we(csr_tval_we)
`endif
    );

    logic any_out, any_we;
    assign any_we  = redirect_valid | prv_mode_we | csr_mstatus_we | (|csr_epc_we) | (|csr_cause_we);
    assign any_out = any_we | flush_req | (|redirect_pc) | (|prv_mode_in) | (|csr_mstatus_in)
                   | (|csr_epc_in) | (|csr_cause_in);

    // transaction capture (filled by run_txn, judged by the test tasks)
    int          c_lat;
    bit          c_flush_ok, c_stray;
    logic        c_prv_we, c_ms_we, c_redir, c_after;
    logic [1:0]  c_prv_in, c_epc_we, c_cause_we;
    logic [31:0] c_ms_in, c_epc_in, c_cause_in, c_redir_pc;

    typedef struct {
        bit          accepted;
        bit          is_ret;
        bit          intr;
        bit          to_m;
        logic [4:0]  code;
        logic [31:0] mstatus;
        logic [1:0]  prv;
        logic [31:0] pc;
    } exp_t;

    // reference: what the architecture says should happen for the current inputs
    function automatic exp_t model();
        exp_t        e;
        int          order[$];
        int          p, line;
        bit          m_en, s_en, tm;
        logic [31:0] ms, tvec;
        e = '{default: 0};
        ms = csr_mstatus;
        p = int'(prv_mode);
        order = '{11, 3, 7, 9, 1, 5};
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (!(i inside {11, 3, 7, 9, 1, 5})) order.push_back(i);
        m_en = (p < 3) || ms[3];
        s_en = (p < 1) || (p == 1 && ms[1]);
        if (exc_valid) begin
            e.accepted = 1; e.code = exc_cause;
            e.to_m = !(csr_medeleg[exc_cause] && p != 3);
        end else begin
            foreach (order[k]) begin
                line = order[k];
                tm = !csr_mideleg[line] || p == 3;
                if (!e.accepted && irq_pending[line] && (tm ? m_en : s_en)) begin
                    e.accepted = 1; e.intr = 1; e.code = 5'(line); e.to_m = tm;
                end
            end
            if (!e.accepted && xret_req != 2'b00) begin
                e.accepted = 1; e.is_ret = 1; e.to_m = xret_req[1];
            end
        end
        tvec = e.to_m ? csr_mtvec : csr_stvec;
        if (e.is_ret && e.to_m) begin
            e.prv = ms[12:11];
            e.mstatus = (ms & ~32'h1888) | (32'(ms[7]) << 3) | 32'h80;
            e.pc = csr_mepc & ~32'h3;
        end else if (e.is_ret) begin
            e.prv = {1'b0, ms[8]};
            e.mstatus = (ms & ~32'h122) | (32'(ms[5]) << 1) | 32'h20;
            e.pc = csr_sepc & ~32'h3;
        end else if (e.to_m) begin
            e.prv = 2'b11;
            e.mstatus = (ms & ~32'h1888) | (32'(ms[3]) << 7) | (32'(p) << 11);
            e.pc = tvec & ~32'h3;
        end else begin
            e.prv = 2'b01;
            e.mstatus = (ms & ~32'h122) | (32'(ms[1]) << 5) | (32'(p & 1) << 8);
            e.pc = tvec & ~32'h3;
        end
        if (e.intr && tvec[1:0] == 2'b01) e.pc = e.pc + 32'(e.code) * 4;
        return e;
    endfunction

    task automatic clear_inputs();
        exc_valid = 0; exc_cause = '0; trap_pc = '0; irq_pending = '0; xret_req = '0;
        prv_mode = 2'b11; csr_mstatus = '0; csr_medeleg = '0; csr_mideleg = '0;
        csr_mtvec = '0; csr_stvec = '0; csr_mepc = '0; csr_sepc = '0; flush_ack = 0;
    endtask

    // drives one accepted event through flush/commit/redirect and records what was seen
    task automatic run_txn(input int ack_delay, input bit scramble);
        c_lat = 0; c_flush_ok = 1; c_stray = 0; c_prv_we = 0; c_ms_we = 0; c_redir = 0; c_after = 1;
        c_prv_in = '0; c_epc_we = '0; c_cause_we = '0; c_ms_in = '0; c_epc_in = '0;
        c_cause_in = '0; c_redir_pc = '0;
        while (!flush_req && c_lat < 6) begin
            @(negedge clk); c_lat++;
            if (any_we) c_stray = 1;
        end
        if (!flush_req) begin
            c_lat = 99; exc_valid = 0; irq_pending = '0; xret_req = '0;
            return;
        end
        if (scramble) begin
            trap_pc = $urandom; csr_mstatus = $urandom; csr_mtvec = $urandom; csr_stvec = $urandom;
            csr_mepc = $urandom; csr_sepc = $urandom; csr_medeleg = $urandom;
            csr_mideleg = $urandom; prv_mode = 2'($urandom); exc_cause = 5'($urandom);
        end
        for (int k = 0; k < ack_delay; k++) begin
            @(negedge clk);
            if (!flush_req) c_flush_ok = 0;
            if (any_we) c_stray = 1;
        end
        flush_ack = 1;
        @(negedge clk);
        flush_ack = 0;
        if (flush_req) c_flush_ok = 0;
        if (redirect_valid) c_stray = 1;
        c_prv_we = prv_mode_we; c_prv_in = prv_mode_in; c_ms_we = csr_mstatus_we; c_ms_in = csr_mstatus_in;
        c_epc_we = csr_epc_we; c_epc_in = csr_epc_in; c_cause_we = csr_cause_we; c_cause_in = csr_cause_in;
        @(negedge clk);
        c_redir = redirect_valid; c_redir_pc = redirect_pc;
        if (prv_mode_we || csr_mstatus_we || csr_epc_we != 0 || csr_cause_we != 0 || flush_req) c_stray = 1;
        exc_valid = 0; irq_pending = '0; xret_req = '0;
        @(negedge clk);
        c_after = any_out;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1; exc_valid = 1; exc_cause = 5'd2;
        #1;
        vectors++; if (any_out !== 1'b0) begin miscompares++; $display("FAIL reset_t0 outputs got=%b exp=0", any_out); end
        repeat (2) @(negedge clk);
        vectors++; if (any_out !== 1'b0) begin miscompares++; $display("FAIL reset_held outputs got=%b exp=0", any_out); end
        exc_valid = 0; rst = 0;
        @(negedge clk);
        vectors++; if (flush_req !== 1'b0) begin miscompares++; $display("FAIL reset_release flush got=%b exp=0", flush_req); end
    endtask

    task automatic test_exc_m();
        clear_inputs();
        prv_mode = 2'b00; exc_valid = 1; exc_cause = 5'd2; csr_mtvec = 32'h8000_0100;
        trap_pc = 32'h1000; csr_mstatus = 32'h8;
        run_txn(3, 0);
        vectors++; if (c_lat !== 1) begin miscompares++; $display("FAIL exc_m flush_latency got=%0d exp=1", c_lat); end
        vectors++; if (!c_flush_ok || c_stray) begin miscompares++; $display("FAIL exc_m timing got=%b%b exp=10", c_flush_ok, c_stray); end
        vectors++; if (c_epc_we !== 2'b10 || c_epc_in !== 32'h1000) begin miscompares++; $display("FAIL exc_m epc got=%b/%h exp=10/00001000", c_epc_we, c_epc_in); end
        vectors++; if (c_cause_we !== 2'b10 || c_cause_in !== 32'd2) begin miscompares++; $display("FAIL exc_m cause got=%b/%h exp=10/00000002", c_cause_we, c_cause_in); end
        vectors++; if (c_prv_we !== 1'b1 || c_prv_in !== 2'b11) begin miscompares++; $display("FAIL exc_m prv got=%b/%b exp=1/11", c_prv_we, c_prv_in); end
        vectors++; if (c_ms_we !== 1'b1 || c_ms_in !== 32'h80) begin miscompares++; $display("FAIL exc_m mstatus got=%b/%h exp=1/00000080", c_ms_we, c_ms_in); end
        vectors++; if (c_redir !== 1'b1 || c_redir_pc !== 32'h8000_0100) begin miscompares++; $display("FAIL exc_m redirect got=%b/%h exp=1/80000100", c_redir, c_redir_pc); end
        vectors++; if (c_after !== 1'b0) begin miscompares++; $display("FAIL exc_m idle_after got=%b exp=0", c_after); end
    endtask

    task automatic test_exc_deleg();
        clear_inputs();
        prv_mode = 2'b00; exc_valid = 1; exc_cause = 5'd8; csr_medeleg = 32'h100;
        csr_stvec = 32'h0000_4000; csr_mtvec = 32'h8000_0000; trap_pc = 32'h2468; csr_mstatus = 32'h2;
        run_txn(0, 0);
        vectors++; if (c_epc_we !== 2'b01 || c_cause_we !== 2'b01 || c_cause_in !== 32'd8) begin miscompares++; $display("FAIL deleg we got=%b/%b/%h exp=01/01/00000008", c_epc_we, c_cause_we, c_cause_in); end
        vectors++; if (c_prv_in !== 2'b01 || c_ms_in !== 32'h20) begin miscompares++; $display("FAIL deleg state got=%b/%h exp=01/00000020", c_prv_in, c_ms_in); end
        vectors++; if (c_redir_pc !== 32'h4000) begin miscompares++; $display("FAIL deleg redirect got=%h exp=00004000", c_redir_pc); end
    endtask

    task automatic test_irq_vectored();
        bit seen;
        clear_inputs();
        prv_mode = 2'b11; csr_mstatus = 32'h8; irq_pending = 16'h0088; csr_mtvec = 32'h8000_0001;
        trap_pc = 32'h3330;
        run_txn(2, 0);
        vectors++; if (c_cause_in !== 32'h8000_0003 || c_cause_we !== 2'b10) begin miscompares++; $display("FAIL irq cause got=%h/%b exp=80000003/10", c_cause_in, c_cause_we); end
        vectors++; if (c_redir_pc !== 32'h8000_000C) begin miscompares++; $display("FAIL irq redirect got=%h exp=8000000c", c_redir_pc); end
        vectors++; if (c_ms_in !== 32'h1880) begin miscompares++; $display("FAIL irq mstatus got=%h exp=00001880", c_ms_in); end
        csr_mstatus = 32'h0; irq_pending = 16'h0088; seen = 0;
        repeat (4) begin @(negedge clk); if (flush_req || any_we) seen = 1; end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL irq_masked accepted got=%b exp=0", seen); end
        irq_pending = '0;
    endtask

    task automatic test_priority_and_mret();
        clear_inputs();
        prv_mode = 2'b11; csr_mstatus = 32'h8; exc_valid = 1; exc_cause = 5'd5;
        irq_pending = 16'h0800; csr_mtvec = 32'h8000_0040; trap_pc = 32'h500;
        run_txn(1, 0);
        vectors++; if (c_cause_in !== 32'd5 || c_redir_pc !== 32'h8000_0040) begin miscompares++; $display("FAIL prio exc_wins got=%h/%h exp=00000005/80000040", c_cause_in, c_redir_pc); end
        clear_inputs();
        prv_mode = 2'b11; csr_mstatus = 32'h880; csr_mepc = 32'h2002; xret_req = 2'b10;
        run_txn(1, 0);
        vectors++; if (c_prv_in !== 2'b01 || c_ms_in !== 32'h88) begin miscompares++; $display("FAIL mret state got=%b/%h exp=01/00000088", c_prv_in, c_ms_in); end
        vectors++; if (c_epc_we !== 2'b00 || c_cause_we !== 2'b00) begin miscompares++; $display("FAIL mret no_epc got=%b/%b exp=00/00", c_epc_we, c_cause_we); end
        vectors++; if (c_redir !== 1'b1 || c_redir_pc !== 32'h2000) begin miscompares++; $display("FAIL mret redirect got=%b/%h exp=1/00002000", c_redir, c_redir_pc); end
    endtask

    task automatic test_reset_midflush();
        bit leak;
        exp_t e;
        clear_inputs();
        prv_mode = 2'b00; exc_valid = 1; exc_cause = 5'd4; csr_mtvec = 32'h100; trap_pc = 32'h700;
        @(negedge clk);
        vectors++; if (flush_req !== 1'b1) begin miscompares++; $display("FAIL rstmid flush_up got=%b exp=1", flush_req); end
        @(negedge clk);
        #2 rst = 1;
        #1;
        vectors++; if (any_out !== 1'b0) begin miscompares++; $display("FAIL rstmid immediate got=%b exp=0", any_out); end
        leak = 0;
        repeat (3) begin @(negedge clk); if (any_out) leak = 1; end
        vectors++; if (leak !== 1'b0) begin miscompares++; $display("FAIL rstmid leak got=%b exp=0", leak); end
        clear_inputs();
        rst = 0;
        @(negedge clk);
        prv_mode = 2'b01; exc_valid = 1; exc_cause = 5'd13; csr_mtvec = 32'h9000_0010;
        trap_pc = 32'h1234_5678; csr_mstatus = 32'h2;
        e = model();
        run_txn(2, 0);
        vectors++; if (c_prv_in !== e.prv || c_ms_in !== e.mstatus) begin miscompares++; $display("FAIL rstmid after state got=%b/%h exp=%b/%h", c_prv_in, c_ms_in, e.prv, e.mstatus); end
        vectors++; if (c_epc_in !== 32'h1234_5678 || c_redir_pc !== e.pc) begin miscompares++; $display("FAIL rstmid after epc/pc got=%h/%h exp=12345678/%h", c_epc_in, c_redir_pc, e.pc); end
    endtask

    task automatic test_random(input int n);
        exp_t        e;
        logic [31:0] pc0;
        logic [1:0]  exp_we;
        int          r;
        bit          seen;
        for (int it = 0; it < n; it++) begin
            clear_inputs();
            r = $urandom_range(0, 2);
            prv_mode = (r == 2) ? 2'b11 : 2'(r);
            csr_mstatus = $urandom; csr_medeleg = $urandom; csr_mideleg = $urandom;
            csr_mtvec = $urandom; csr_stvec = $urandom; csr_mepc = $urandom; csr_sepc = $urandom;
            trap_pc = $urandom; exc_cause = 5'($urandom);
            exc_valid = ($urandom_range(0, 3) == 0);
            irq_pending = NUM_IRQ'($urandom & $urandom & $urandom);
            r = $urandom_range(0, 2);
            xret_req = (r == 0) ? 2'b00 : ((r == 1) ? 2'b01 : 2'b10);
            pc0 = trap_pc;
            e = model();
            if (!e.accepted) begin
                seen = 0;
                repeat (3) begin @(negedge clk); if (flush_req || any_we) seen = 1; end
                vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rnd%0d spurious got=%b exp=0", it, seen); end
                continue;
            end
            run_txn($urandom_range(0, 4), 1);
            exp_we = e.is_ret ? 2'b00 : (e.to_m ? 2'b10 : 2'b01);
            vectors++; if (c_lat !== 1 || !c_flush_ok || c_stray || c_after !== 1'b0) begin miscompares++; $display("FAIL rnd%0d timing got=%0d/%b/%b/%b exp=1/1/0/0", it, c_lat, c_flush_ok, c_stray, c_after); end
            vectors++; if (c_prv_we !== 1'b1 || c_prv_in !== e.prv) begin miscompares++; $display("FAIL rnd%0d prv got=%b/%b exp=1/%b", it, c_prv_we, c_prv_in, e.prv); end
            vectors++; if (c_ms_we !== 1'b1 || c_ms_in !== e.mstatus) begin miscompares++; $display("FAIL rnd%0d mstatus got=%b/%h exp=1/%h", it, c_ms_we, c_ms_in, e.mstatus); end
            vectors++; if (c_epc_we !== exp_we || c_cause_we !== exp_we) begin miscompares++; $display("FAIL rnd%0d we got=%b/%b exp=%b", it, c_epc_we, c_cause_we, exp_we); end
            if (!e.is_ret) begin
                vectors++; if (c_epc_in !== pc0) begin miscompares++; $display("FAIL rnd%0d epc got=%h exp=%h", it, c_epc_in, pc0); end
                vectors++; if (c_cause_in !== {e.intr, 26'b0, e.code}) begin miscompares++; $display("FAIL rnd%0d cause got=%h exp=%h", it, c_cause_in, {e.intr, 26'b0, e.code}); end
            end
            vectors++; if (c_redir !== 1'b1 || c_redir_pc !== e.pc) begin miscompares++; $display("FAIL rnd%0d redirect got=%b/%h exp=1/%h", it, c_redir, c_redir_pc, e.pc); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_exc_m();
        test_exc_deleg();
        test_irq_vectored();
        test_priority_and_mret();
        test_reset_midflush();
        test_random(80);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
